// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-channel, WIDTH-bit multiplexer with one registered output stage.
// Every port uses a valid/ready handshake. The grant comes either from the
// select input (MODE 0) or from a round-robin arbiter (MODE 1). The output
// register reloads whenever it is empty or being drained in the same cycle,
// so a continuously ready sink sees one word per clock.
module mux_n_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 3,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NCH*WIDTH-1:0] i_in_data,
    input  logic [NCH-1:0]       i_in_valid,
    output logic [NCH-1:0]       o_in_ready,
    input  logic [SELW-1:0]      i_sel,
    output logic [WIDTH-1:0]     o_out_data,
    output logic [SELW-1:0]      o_out_ch,
    output logic                 o_out_valid,
    input  logic                 i_out_ready
);

    // Channel count and last channel index at select width; one extra bit on
    // the count so that NCH == 2**SELW is still representable.
    localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_ch;
    logic             r_valid;
    logic [SELW-1:0]  r_rr_ptr;

    logic             w_load_en;
    logic [SELW-1:0]  w_grant_sel;
    logic [SELW-1:0]  w_grant_rr;
    logic             w_rr_found;
    logic [SELW-1:0]  w_grant;
    logic             w_grant_ok;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_valid;
    logic             w_xfer;
    logic [SELW-1:0]  w_rr_next;
    logic [SELW-1:0]  w_rr_idx [NCH];

    // The output register can take a word when it is empty or being emptied now.
    assign w_load_en = ~r_valid | i_out_ready;

    // Select-driven grant; out-of-range selects fall back to the last channel.
    assign w_grant_sel = ({1'b0, i_sel} >= NCH_W) ? LAST_CH : i_sel;

    // Search order for the arbiter: entry k is channel (rr_ptr + k) mod NCH.
    // Both operands are below NCH, so one conditional subtraction wraps it.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_rr_order
            logic [SELW:0] w_sum;
            assign w_sum         = {1'b0, r_rr_ptr} + (SELW + 1)'(gi);
            assign w_rr_idx[gi]  = (w_sum >= NCH_W) ? SELW'(w_sum - NCH_W) : w_sum[SELW-1:0];
        end
    endgenerate

    // Round-robin pick: the first valid channel in search order. Scanning from
    // the far end lets the nearest hit overwrite any farther one.
    always_comb begin
        w_grant_rr = '0;
        w_rr_found = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            for (int i = 0; i < NCH; i++) begin
                if (w_rr_idx[k] == SELW'(i) && i_in_valid[i]) begin
                    w_grant_rr = w_rr_idx[k];
                    w_rr_found = 1'b1;
                end
            end
        end
    end

    // A single channel is always granted. In select mode the grant does not
    // depend on in_valid, which keeps in_valid out of the in_ready cone.
    assign w_grant    = (NCH == 1) ? {SELW{1'b0}} : ((MODE == 1) ? w_grant_rr : w_grant_sel);
    assign w_grant_ok = (NCH == 1 || MODE != 1) ? 1'b1 : w_rr_found;

    // Route the granted channel's word and valid flag.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == SELW'(i)) begin
                w_sel_data  = i_in_data[i*WIDTH +: WIDTH];
                w_sel_valid = i_in_valid[i];
            end
        end
    end

    assign w_xfer    = w_load_en & w_grant_ok & w_sel_valid;
    assign w_rr_next = (w_grant == LAST_CH) ? {SELW{1'b0}} : (w_grant + SELW'(1));

    // Ready goes only to the granted channel, and never while reset is held.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
            assign o_in_ready[gi] = w_load_en & w_grant_ok & (w_grant == SELW'(gi)) & i_rst_n;
        end
    endgenerate

    // Output stage and arbiter pointer: load on transfer, otherwise drain or hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data   <= '0;
            r_ch     <= '0;
            r_valid  <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            if (w_xfer) begin
                r_data  <= w_sel_data;
                r_ch    <= w_grant;
                r_valid <= 1'b1;
                if (MODE == 1) begin
                    r_rr_ptr <= w_rr_next;
                end
            end else if (r_valid && i_out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_out_data  = r_data;
    assign o_out_ch    = r_ch;
    assign o_out_valid = r_valid;

endmodule
